rank_dispatch: RTL and testbench
================================

RANK_DISPATCH -- requirements
Module: rank_dispatch

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_RANK_OPS, 4, number of attached rank engines (2..2**RANK_CODE_BITS).
- RANK_CODE_BITS, 2, width of rank_op_in.
- DEFAULT_OP, 0, engine used for out-of-range rank_op_in.
- META_WIDTH, 16, metadata width.
- FLOW_ID_WIDTH, 16, flow ID width.
- FLOW_WEIGHT_WIDTH, 8, flow weight width.
- RANK_WIDTH, 16, rank width.
- L2_DEPTH, 4, log2 of input and output FIFO depth.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- busy, out, 1, input FIFO nearly full.
- insert, in, 1, write request.
- meta_in, in, META_WIDTH, metadata.
- rank_op_in, in, RANK_CODE_BITS, engine select.
- flowID_in, in, FLOW_ID_WIDTH, flow ID.
- flow_weight_in, in, FLOW_WEIGHT_WIDTH, flow weight.
- remove, in, 1, pop output head.
- valid_out, out, 1, output FIFO non-empty.
- rank_out, out, RANK_WIDTH, head rank.
- meta_out, out, META_WIDTH, head metadata.
- op_out, out, RANK_CODE_BITS, engine that produced the head.
- eng_busy, in, NUM_RANK_OPS, per-engine busy.
- eng_insert, out, NUM_RANK_OPS, one-hot insert strobe.
- eng_meta_in, out, META_WIDTH, broadcast metadata.
- eng_flowID_in, out, FLOW_ID_WIDTH, broadcast flow ID.
- eng_flow_weight_in, out, FLOW_WEIGHT_WIDTH, broadcast weight.
- eng_valid, in, NUM_RANK_OPS, per-engine result ready.
- eng_rank, in, NUM_RANK_OPS*RANK_WIDTH, flattened ranks; engine k at slice k.
- eng_meta, in, NUM_RANK_OPS*META_WIDTH, flattened metadata.
- eng_remove, out, NUM_RANK_OPS, one-hot pop strobe.
- drop_count, out, 16, inserts refused while busy.
- bad_op_count, out, 16, out-of-range rank_op_in seen.

Function
REQ-003 busy SHALL equal input FIFO nearly_full, combinationally.
REQ-004 Insert with busy=0 SHALL enqueue the request; with busy=1 it SHALL be discarded and drop_count SHALL increment, saturating at 16'hFFFF.
REQ-005 Enqueue with rank_op_in >= NUM_RANK_OPS SHALL substitute DEFAULT_OP and increment bad_op_count (saturating); metadata SHALL be kept.
REQ-006 Dispatch: when the input FIFO is non-empty and eng_busy[head op]=0, eng_insert[head op] SHALL pulse for one cycle in the same cycle as the FIFO pop; at most one strobe per cycle.
REQ-007 Dispatch SHALL be strictly in order; a busy head engine SHALL block all later entries.
REQ-008 eng_*_in SHALL carry head fields when eng_insert is nonzero, else zero.
REQ-009 Latency: insert at cycle t SHALL give eng_insert no earlier than t+1 (1 cycle minimum).
REQ-010 Collection SHALL be round-robin over eng_valid, starting from rr_ptr; grant g asserts eng_remove[g] and writes {eng_rank[g], eng_meta[g], g} to the output FIFO in the same cycle.
REQ-011 After a grant to g, rr_ptr SHALL become (g+1) mod NUM_RANK_OPS; it SHALL not change without a grant.
REQ-012 No grant SHALL occur while the output FIFO is nearly full; eng_remove SHALL stay 0.
REQ-013 valid_out SHALL equal ~output_empty; {rank_out, meta_out, op_out} SHALL show the head, fall-through.
REQ-014 remove with valid_out=1 SHALL pop the head; remove with valid_out=0 SHALL be ignored.
REQ-015 An engine result granted at t SHALL appear on valid_out at t+1.
REQ-016 Simultaneous enqueue and dispatch, and simultaneous grant and remove, SHALL both complete in the same cycle.

Reset
REQ-017 rst, sampled on clk, SHALL empty both FIFOs, set rr_ptr=0, and clear both counters.
REQ-018 During reset, and in the first cycle after it, busy=0, valid_out=0, eng_insert=0, and eng_remove=0.
REQ-019 Reset mid-operation SHALL discard all queued entries without emitting strobes.

Structure
REQ-020 Rank-op codes (STRICT_OP=0, RR_OP=1, WRR_OP=2, FQ_OP=3) and RANK_CODE_BITS SHALL live in the shared package rank_pipe_pkg.
REQ-021 Both queues SHALL instantiate the existing fallthrough_small_fifo.
REQ-022 The round-robin arbiter SHALL be a sub-module rr_arbiter (parametrised N, request in, one-hot grant out, pointer update on grant).

Verification
REQ-023 Insert ops 0,1,2,3 with meta 0x10..0x13, all engines idle -> eng_insert 0001,0010,0100,1000 on consecutive cycles, meta 0x10..0x13.
REQ-024 Set eng_busy=0010, insert ops 1 then 0 -> no strobe; op0 blocked; release at cycle 5 -> op1 dispatched, then op0.
REQ-025 Hold eng_valid=1111 with remove=1 -> grants 0,1,2,3,0 and op_out sequence 0,1,2,3,0.
REQ-026 Insert 20 entries with eng_busy=1111 -> busy asserts near depth 16; drop_count equals refused inserts.
REQ-027 Insert with rank_op_in=3 when NUM_RANK_OPS=3 -> dispatched to engine 0, bad_op_count=1.
REQ-028 Fill the output FIFO with remove=0 -> eng_remove=0 while nearly full; assert rst -> valid_out=0 next cycle and counters=0.

Source files
------------

// File: rtl/rank_pipe_pkg.sv
// Shared rank-pipeline definitions: rank-op engine codes and a saturating counter helper.
package rank_pipe_pkg;

    localparam int RANK_CODE_BITS = 2;

    typedef enum logic [RANK_CODE_BITS-1:0] {
        STRICT_OP = 2'd0,
        RR_OP     = 2'd1,
        WRR_OP    = 2'd2,
        FQ_OP     = 2'd3
    } rank_op_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small FIFO whose head is visible on dout whenever empty is low (zero read latency).
// Writes while full and reads while empty are ignored; nearly_full leaves one slot of slack.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      do_wr;
    logic                      do_rd;

    assign empty       = (depth == '0);
    assign full        = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
    assign do_rd       = rd_en & ~empty;
    assign do_wr       = wr_en & (~full | do_rd);
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            depth <= depth + (MAX_DEPTH_BITS+1)'(do_wr) - (MAX_DEPTH_BITS+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, combinational.
// ptr moves to one past the winner only on a grant; callers mask req to apply backpressure.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gidx       = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/rank_dispatch.sv
// Queues rank requests, dispatches them in order to per-op engines, and collects results round-robin.
// Min 1 cycle insert->engine strobe, grant->valid_out 1 cycle; busy/eng_busy/output nearly-full stall.
module rank_dispatch #(
    parameter int NUM_RANK_OPS      = 4,
    parameter int RANK_CODE_BITS    = rank_pipe_pkg::RANK_CODE_BITS,
    parameter int DEFAULT_OP        = int'(rank_pipe_pkg::STRICT_OP),
    parameter int META_WIDTH        = 16,
    parameter int FLOW_ID_WIDTH     = 16,
    parameter int FLOW_WEIGHT_WIDTH = 8,
    parameter int RANK_WIDTH        = 16,
    parameter int L2_DEPTH          = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                busy,
    input  logic                                insert,
    input  logic [META_WIDTH-1:0]               meta_in,
    input  logic [RANK_CODE_BITS-1:0]           rank_op_in,
    input  logic [FLOW_ID_WIDTH-1:0]            flowID_in,
    input  logic [FLOW_WEIGHT_WIDTH-1:0]        flow_weight_in,
    input  logic                                remove,
    output logic                                valid_out,
    output logic [RANK_WIDTH-1:0]               rank_out,
    output logic [META_WIDTH-1:0]               meta_out,
    output logic [RANK_CODE_BITS-1:0]           op_out,
    input  logic [NUM_RANK_OPS-1:0]             eng_busy,
    output logic [NUM_RANK_OPS-1:0]             eng_insert,
    output logic [META_WIDTH-1:0]               eng_meta_in,
    output logic [FLOW_ID_WIDTH-1:0]            eng_flowID_in,
    output logic [FLOW_WEIGHT_WIDTH-1:0]        eng_flow_weight_in,
    input  logic [NUM_RANK_OPS-1:0]             eng_valid,
    input  logic [NUM_RANK_OPS*RANK_WIDTH-1:0]  eng_rank,
    input  logic [NUM_RANK_OPS*META_WIDTH-1:0]  eng_meta,
    output logic [NUM_RANK_OPS-1:0]             eng_remove,
    output logic [15:0]                         drop_count,
    output logic [15:0]                         bad_op_count
);
    localparam int IN_W  = META_WIDTH + FLOW_ID_WIDTH + FLOW_WEIGHT_WIDTH + RANK_CODE_BITS;
    localparam int OUT_W = RANK_WIDTH + META_WIDTH + RANK_CODE_BITS;

    // Strobes stay quiet during reset and the cycle after it.
    logic rst_q;
    logic live;
    always_ff @(posedge clk) rst_q <= rst;
    assign live = ~rst & ~rst_q;

    logic                          in_bad, in_wr, in_rd, in_empty, in_nf, in_full;
    logic [RANK_CODE_BITS-1:0]     in_op;
    logic [IN_W-1:0]               in_din, in_dout;
    logic [META_WIDTH-1:0]         hd_meta;
    logic [FLOW_ID_WIDTH-1:0]      hd_flow;
    logic [FLOW_WEIGHT_WIDTH-1:0]  hd_weight;
    logic [RANK_CODE_BITS-1:0]     hd_op;
    logic [NUM_RANK_OPS-1:0]       hd_sel;

    assign in_bad = ({1'b0, rank_op_in} >= (RANK_CODE_BITS+1)'(NUM_RANK_OPS));
    assign in_op  = in_bad ? RANK_CODE_BITS'(DEFAULT_OP) : rank_op_in;
    assign in_din = {meta_in, flowID_in, flow_weight_in, in_op};
    assign busy   = in_nf & ~rst;
    assign in_wr  = insert & ~busy & ~rst;

    fallthrough_small_fifo #(.WIDTH(IN_W), .MAX_DEPTH_BITS(L2_DEPTH)) u_in_fifo (
        .clk(clk), .reset(rst), .din(in_din), .wr_en(in_wr), .rd_en(in_rd),
        .dout(in_dout), .full(in_full), .nearly_full(in_nf), .empty(in_empty)
    );

    assign {hd_meta, hd_flow, hd_weight, hd_op} = in_dout;
    assign hd_sel = NUM_RANK_OPS'(1) << hd_op;

    // Only the head may dispatch, so a busy head engine holds back everything behind it.
    assign in_rd              = live & ~in_empty & ~|(eng_busy & hd_sel);
    assign eng_insert         = in_rd ? hd_sel    : '0;
    assign eng_meta_in        = in_rd ? hd_meta   : '0;
    assign eng_flowID_in      = in_rd ? hd_flow   : '0;
    assign eng_flow_weight_in = in_rd ? hd_weight : '0;

    logic                      out_nf, out_empty, out_full;
    logic [NUM_RANK_OPS-1:0]   arb_req, grant;
    logic [RANK_WIDTH-1:0]     sel_rank;
    logic [META_WIDTH-1:0]     sel_meta;
    logic [RANK_CODE_BITS-1:0] sel_op;
    logic [OUT_W-1:0]          out_dout;

    assign arb_req = eng_valid & {NUM_RANK_OPS{live & ~out_nf}};

    rr_arbiter #(.N(NUM_RANK_OPS)) u_arb (
        .clk(clk), .rst(rst), .req(arb_req), .grant(grant)
    );

    always_comb begin
        sel_rank = '0;
        sel_meta = '0;
        sel_op   = '0;
        for (int k = 0; k < NUM_RANK_OPS; k++) begin
            if (grant[k]) begin
                sel_rank = eng_rank[k*RANK_WIDTH +: RANK_WIDTH];
                sel_meta = eng_meta[k*META_WIDTH +: META_WIDTH];
                sel_op   = RANK_CODE_BITS'(k);
            end
        end
    end

    assign eng_remove = grant;
    assign valid_out  = ~out_empty & ~rst;

    fallthrough_small_fifo #(.WIDTH(OUT_W), .MAX_DEPTH_BITS(L2_DEPTH)) u_out_fifo (
        .clk(clk), .reset(rst), .din({sel_rank, sel_meta, sel_op}), .wr_en(|grant),
        .rd_en(remove & valid_out), .dout(out_dout), .full(out_full),
        .nearly_full(out_nf), .empty(out_empty)
    );

    assign {rank_out, meta_out, op_out} = out_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count   <= '0;
            bad_op_count <= '0;
        end else begin
            if (insert && busy)   drop_count   <= rank_pipe_pkg::sat_inc16(drop_count);
            if (in_wr && in_bad)  bad_op_count <= rank_pipe_pkg::sat_inc16(bad_op_count);
        end
    end

endmodule

// File: tb/tb_rank_dispatch.sv
// Bench for rank_dispatch: dispatch and collection scoreboards plus table-driven and corner sequences.
`timescale 1ns/1ps
module tb_rank_dispatch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        busy, insert, remove, valid_out;
    logic [15:0] meta_in, flowID_in, rank_out, meta_out;
    logic [15:0] eng_meta_in, eng_flowID_in, drop_count, bad_op_count;
    logic [1:0]  rank_op_in, op_out;
    logic [7:0]  flow_weight_in, eng_flow_weight_in;
    logic [3:0]  eng_busy, eng_insert, eng_valid, eng_remove;
    logic [63:0] eng_rank, eng_meta;

    rank_dispatch u_dut (
        .clk(clk), .rst(rst), .busy(busy), .insert(insert), .meta_in(meta_in),
        .rank_op_in(rank_op_in), .flowID_in(flowID_in), .flow_weight_in(flow_weight_in),
        .remove(remove), .valid_out(valid_out), .rank_out(rank_out), .meta_out(meta_out),
        .op_out(op_out), .eng_busy(eng_busy), .eng_insert(eng_insert), .eng_meta_in(eng_meta_in),
        .eng_flowID_in(eng_flowID_in), .eng_flow_weight_in(eng_flow_weight_in),
        .eng_valid(eng_valid), .eng_rank(eng_rank), .eng_meta(eng_meta),
        .eng_remove(eng_remove), .drop_count(drop_count), .bad_op_count(bad_op_count)
    );

    // Three-engine instance for out-of-range op substitution.
    logic        d3_busy, d3_insert, d3_valid_out;
    logic [15:0] d3_meta_in, d3_rank_out, d3_meta_out, d3_eng_meta_in, d3_eng_flow, d3_drop, d3_bad;
    logic [1:0]  d3_op_in, d3_op_out;
    logic [7:0]  d3_eng_wt;
    logic [2:0]  d3_eng_insert, d3_eng_remove;

    rank_dispatch #(.NUM_RANK_OPS(3)) u_dut3 (
        .clk(clk), .rst(rst), .busy(d3_busy), .insert(d3_insert), .meta_in(d3_meta_in),
        .rank_op_in(d3_op_in), .flowID_in(16'h0), .flow_weight_in(8'h0),
        .remove(1'b0), .valid_out(d3_valid_out), .rank_out(d3_rank_out), .meta_out(d3_meta_out),
        .op_out(d3_op_out), .eng_busy(3'b000), .eng_insert(d3_eng_insert),
        .eng_meta_in(d3_eng_meta_in), .eng_flowID_in(d3_eng_flow), .eng_flow_weight_in(d3_eng_wt),
        .eng_valid(3'b000), .eng_rank(48'h0), .eng_meta(48'h0),
        .eng_remove(d3_eng_remove), .drop_count(d3_drop), .bad_op_count(d3_bad)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: got %0h expected no event", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] meta;
        logic [15:0] flow;
        logic [7:0]  wt;
    } disp_t;

    typedef struct packed {
        logic [15:0] rank;
        logic [15:0] meta;
        logic [1:0]  op;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] meta;
        logic [3:0]  exp_ins;
    } vec_t;

    disp_t disp_q[$];
    res_t  res_q[$];
    disp_t mon_d;
    res_t  mon_r;
    vec_t  tbl[4];
    int    grant_seq[5];

    task automatic drive_ins(input logic [1:0] op, input logic [15:0] m);
        disp_t e;
        insert         = 1'b1;
        rank_op_in     = op;
        meta_in        = m;
        flowID_in      = m ^ 16'hF0F0;
        flow_weight_in = m[7:0] + 8'd3;
        e.op   = op;
        e.meta = m;
        e.flow = m ^ 16'hF0F0;
        e.wt   = m[7:0] + 8'd3;
        disp_q.push_back(e);
    endtask

    // Dispatch scoreboard: every engine strobe must match the oldest accepted insert.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (eng_insert != 4'b0) begin
                if (disp_q.size() == 0) begin
                    fail_now("unexpected_eng_insert", eng_insert);
                end else begin
                    mon_d = disp_q.pop_front();
                    chk("sb_eng_insert", eng_insert, 4'b0001 << mon_d.op);
                    chk("sb_eng_meta", eng_meta_in, mon_d.meta);
                    chk("sb_eng_flow", eng_flowID_in, mon_d.flow);
                    chk("sb_eng_weight", eng_flow_weight_in, mon_d.wt);
                end
            end else begin
                chk("idle_fields_zero", {eng_meta_in, eng_flowID_in} | 32'(eng_flow_weight_in), 0);
            end
        end
    end

    // Collection scoreboard: every popped head must match the expected grant order.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_out && remove) begin
            if (res_q.size() == 0) begin
                fail_now("unexpected_result", {rank_out, meta_out});
            end else begin
                mon_r = res_q.pop_front();
                chk("sb_rank_out", rank_out, mon_r.rank);
                chk("sb_meta_out", meta_out, mon_r.meta);
                chk("sb_op_out", op_out, mon_r.op);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd0, 16'h0010, 4'b0001};
        tbl[1] = '{2'd1, 16'h0011, 4'b0010};
        tbl[2] = '{2'd2, 16'h0012, 4'b0100};
        tbl[3] = '{2'd3, 16'h0013, 4'b1000};
        grant_seq = '{0, 1, 2, 3, 0};

        rst = 1'b1; insert = 1'b0; remove = 1'b0; meta_in = '0; rank_op_in = '0;
        flowID_in = '0; flow_weight_in = '0; eng_busy = '0; eng_valid = 4'hF;
        d3_insert = 1'b0; d3_meta_in = '0; d3_op_in = '0;
        for (int k = 0; k < 4; k++) begin
            eng_rank[k*16 +: 16] = 16'h0100 + 16'(k);
            eng_meta[k*16 +: 16] = 16'h0200 + 16'(k);
        end

        // Reset: outputs quiet during reset and in the first cycle after it.
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_eng_insert", eng_insert, 0);
        chk("rst_eng_remove", eng_remove, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_eng_remove", eng_remove, 0);
        chk("post_rst_valid_out", valid_out, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_drop", drop_count, 0);
        chk("post_rst_bad", bad_op_count, 0);
        eng_valid = 4'h0;
        tick();

        // One insert per op on back-to-back cycles, all engines idle.
        for (int i = 0; i < 5; i++) begin
            insert = 1'b0;
            if (i < 4) drive_ins(tbl[i].op, tbl[i].meta);
            @(negedge clk);
            chk($sformatf("consec_ins%0d", i), eng_insert, (i > 0) ? tbl[i-1].exp_ins : 4'b0000);
            tick();
        end
        insert = 1'b0;

        // Busy head engine blocks a later entry; release at cycle 5.
        eng_busy = 4'b0010;
        for (int c = 0; c < 7; c++) begin
            insert = 1'b0;
            if (c == 0) drive_ins(2'd1, 16'h0021);
            if (c == 1) drive_ins(2'd0, 16'h0020);
            if (c == 5) eng_busy = 4'b0000;
            @(negedge clk);
            chk($sformatf("blocked_c%0d", c), eng_insert,
                (c == 5) ? 4'b0010 : (c == 6) ? 4'b0001 : 4'b0000);
            tick();
        end
        chk("blocked_drained", disp_q.size(), 0);

        // Round-robin collection with constant eng_valid and remove held high.
        foreach (grant_seq[s])
            res_q.push_back('{16'h0100 + 16'(grant_seq[s]), 16'h0200 + 16'(grant_seq[s]), 2'(grant_seq[s])});
        remove = 1'b1;
        for (int c = 0; c < 6; c++) begin
            eng_valid = (c < 5) ? 4'hF : 4'h0;
            @(negedge clk);
            chk($sformatf("rr_grant_c%0d", c), eng_remove, (c < 5) ? (4'b0001 << grant_seq[c]) : 4'b0000);
            if (c > 0) begin
                chk($sformatf("rr_valid_c%0d", c), valid_out, 1);
                chk($sformatf("rr_op_out_c%0d", c), op_out, grant_seq[c-1]);
            end
            tick();
        end
        remove = 1'b0;
        @(negedge clk);
        chk("rr_results_drained", res_q.size(), 0);
        chk("rr_valid_after", valid_out, 0);
        tick();

        // Fill the input FIFO behind busy engines; 15 accepted, 5 refused.
        eng_busy = 4'hF;
        for (int i = 0; i < 20; i++) begin
            insert = 1'b0;
            if (i < 15) drive_ins(2'(i % 4), 16'h0300 + 16'(i));
            else begin
                insert = 1'b1;
                rank_op_in = 2'(i % 4);
                meta_in = 16'h0300 + 16'(i);
            end
            @(negedge clk);
            chk($sformatf("fill_busy_%0d", i), busy, (i >= 15) ? 1 : 0);
            tick();
        end
        insert = 1'b0;
        @(negedge clk);
        chk("drop_count", drop_count, 5);
        eng_busy = 4'h0;
        for (int w = 0; w < 40 && disp_q.size() != 0; w++) tick();
        @(negedge clk);
        chk("fill_drained", disp_q.size(), 0);
        chk("fill_busy_clear", busy, 0);
        tick();

        // Output FIFO fills with remove low; collection stops once nearly full.
        eng_valid = 4'hF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("out_fill_remove_%0d", c), eng_remove != 4'b0, (c < 15) ? 1 : 0);
            tick();
        end
        chk("out_fill_valid", valid_out, 1);

        // Queue work that reset must discard.
        eng_busy = 4'hF;
        for (int i = 0; i < 3; i++) begin
            insert = 1'b1; rank_op_in = 2'(i); meta_in = 16'h0400 + 16'(i);
            tick();
        end
        insert = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_eng_remove", eng_remove, 0);
        chk("mid_rst_valid_out", valid_out, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        eng_busy = 4'h0;
        @(negedge clk);
        chk("after_rst_valid_out", valid_out, 0);
        chk("after_rst_eng_remove", eng_remove, 0);
        chk("after_rst_drop", drop_count, 0);
        chk("after_rst_bad", bad_op_count, 0);
        eng_valid = 4'h0;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            chk($sformatf("discard_insert_%0d", c), eng_insert, 0);
            chk($sformatf("discard_valid_%0d", c), valid_out, 0);
        end
        tick();

        // Out-of-range op on the three-engine instance goes to engine 0.
        d3_insert = 1'b1; d3_op_in = 2'd3; d3_meta_in = 16'h0077;
        tick();
        d3_insert = 1'b0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            if (d3_eng_insert != 3'b000) break;
            tick();
        end
        chk("bad_op_eng_insert", d3_eng_insert, 3'b001);
        chk("bad_op_meta", d3_eng_meta_in, 16'h0077);
        tick();
        chk("bad_op_count", d3_bad, 1);
        d3_insert = 1'b1; d3_op_in = 2'd2; d3_meta_in = 16'h0078;
        tick();
        d3_insert = 1'b0;
        @(negedge clk);
        chk("good_op_eng_insert", d3_eng_insert, 3'b100);
        tick();
        chk("good_op_bad_count", d3_bad, 1);
        chk("tb_queues_empty", disp_q.size() + res_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
